mod_updown_counter: RTL and testbench

//  Parametrised successor to the fixed 4-bit up counter.

---
 rtl/mod_updown_counter_pkg.sv | 23 ++
 rtl/mod_updown_counter_tick_prescaler.sv | 35 +++
 rtl/mod_updown_counter.sv | 97 +++++++++
 tb/tb_mod_updown_counter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mod_updown_counter_pkg.sv
// Shared constants and helpers for the modulo-N up/down counter and the
// timer blocks that reuse its tick prescaler.
package mod_updown_counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DN    = 1'b0;

    localparam int   MODE_WRAP = 0;
    localparam int   MODE_SAT  = 1;

    // Bits needed to hold the values 0..n-1; never less than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        for (int i = 0; i < 31; i++) begin
            if ((1 << w) < n) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/mod_updown_counter_tick_prescaler.sv
// Tick prescaler: emits one tick per PRESCALE enabled cycles. The phase is kept
// as a down-counter reloaded on restart and on each tick.
module tick_prescaler
    import mod_updown_counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic en,
    output logic tick
);

    localparam int             PW     = cnt_width(PRESCALE);
    localparam logic [PW-1:0]  RELOAD = PW'(PRESCALE - 1);

    logic [PW-1:0] remain;

    // With PRESCALE=1 the reload value is zero, so tick degenerates to en.
    assign tick = en & (remain == '0);

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            remain <= RELOAD;
        end else if (en) begin
            if (remain == '0) begin
                remain <= RELOAD;
            end else begin
                remain <= remain - PW'(1);
            end
        end
    end

endmodule

// File: rtl/mod_updown_counter.sv
// Synchronous modulo-N up/down counter with parallel load, clear, prescaled
// enable, wrap/saturate bound handling and terminal-count/wrap/sat status.
module mod_updown_counter
    import mod_updown_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int PRESCALE = 1,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             sat
);

    generate
        if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
            $error("mod_updown_counter: MODULUS must lie in 2..2**WIDTH");
        end
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("mod_updown_counter: PRESCALE must be at least 1");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_Q    = WIDTH'(MODULUS - 1);
    localparam logic             SAT_MODE = (SATURATE == MODE_SAT);

    logic             tick;
    logic             at_bound;
    logic             step_wraps;
    logic             step_blocked;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] load_clamped;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_tick_prescaler (
        .clk     (clk),
        .reset   (reset),
        .restart (clear | load),
        .en      (en),
        .tick    (tick)
    );

    assign tc           = (up_dn == DIR_UP) ? (q == MAX_Q) : (q == '0);
    assign at_bound     = tc;
    assign step_wraps   = tick & at_bound & ~SAT_MODE;
    assign step_blocked = tick & at_bound & SAT_MODE;
    assign load_clamped = (load_val > MAX_Q) ? MAX_Q : load_val;

    // A blocked step leaves q unchanged, so only the wrap case needs a bound value.
    always_comb begin
        q_step = q;
        if (up_dn == DIR_UP) begin
            if (!at_bound) begin
                q_step = q + WIDTH'(1);
            end else if (!SAT_MODE) begin
                q_step = '0;
            end
        end else begin
            if (!at_bound) begin
                q_step = q - WIDTH'(1);
            end else if (!SAT_MODE) begin
                q_step = MAX_Q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            q    <= '0;
            wrap <= 1'b0;
            sat  <= 1'b0;
        end else if (load) begin
            q    <= load_clamped;
            wrap <= 1'b0;
            sat  <= 1'b0;
        end else begin
            wrap <= step_wraps;
            if (tick) begin
                q <= q_step;
            end
            if (step_blocked) begin
                sat <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: four parameter sets driven by shared stimulus,
// checked every cycle against an arithmetic model plus directed literal checks.
module tb_mod_updown_counter;

    logic       clk = 1'b0;
    logic       reset, clear, load, en, up_dn;
    logic [3:0] load_val;

    logic [3:0] q_o    [4];
    logic       tc_o   [4];
    logic       wrap_o [4];
    logic       sat_o  [4];
    logic [2:0] q_d;

    localparam int MODS [4] = '{10, 10, 16, 8};
    localparam int PRES [4] = '{1, 1, 3, 2};
    localparam int SATS [4] = '{0, 1, 0, 1};
    localparam int WID  [4] = '{4, 4, 4, 3};

    int m_q   [4];
    int m_ph  [4];
    bit m_wrap[4];
    bit m_sat [4];
    bit model_ok = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) u_a (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .up_dn(up_dn), .q(q_o[0]), .tc(tc_o[0]), .wrap(wrap_o[0]), .sat(sat_o[0]));

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(1)) u_b (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .up_dn(up_dn), .q(q_o[1]), .tc(tc_o[1]), .wrap(wrap_o[1]), .sat(sat_o[1]));

    mod_updown_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(3), .SATURATE(0)) u_c (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .up_dn(up_dn), .q(q_o[2]), .tc(tc_o[2]), .wrap(wrap_o[2]), .sat(sat_o[2]));

    mod_updown_counter #(.WIDTH(3), .MODULUS(8), .PRESCALE(2), .SATURATE(1)) u_d (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val[2:0]),
        .en(en), .up_dn(up_dn), .q(q_d), .tc(tc_o[3]), .wrap(wrap_o[3]), .sat(sat_o[3]));

    assign q_o[3] = {1'b0, q_d};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: q is an integer in 0..M-1, the prescaler is a count of enabled
    // cycles since the last restart, taken modulo PRESCALE.
    always @(posedge clk) begin
        int lv;
        for (int i = 0; i < 4; i++) begin
            lv = int'(load_val) % (1 << WID[i]);
            if (reset || clear) begin
                m_q[i] = 0; m_ph[i] = 0; m_sat[i] = 0; m_wrap[i] = 0;
            end else if (load) begin
                m_q[i] = (lv > MODS[i] - 1) ? MODS[i] - 1 : lv;
                m_ph[i] = 0; m_sat[i] = 0; m_wrap[i] = 0;
            end else begin
                m_wrap[i] = 0;
                if (en) begin
                    m_ph[i]++;
                    if (m_ph[i] == PRES[i]) begin
                        m_ph[i] = 0;
                        if (up_dn) begin
                            if (m_q[i] < MODS[i] - 1)  m_q[i]++;
                            else if (SATS[i] != 0)     m_sat[i] = 1;
                            else begin m_q[i] = 0; m_wrap[i] = 1; end
                        end else begin
                            if (m_q[i] > 0)            m_q[i]--;
                            else if (SATS[i] != 0)     m_sat[i] = 1;
                            else begin m_q[i] = MODS[i] - 1; m_wrap[i] = 1; end
                        end
                    end
                end
            end
        end
        if (reset) model_ok = 1'b1;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("q%0d", i),    32'(q_o[i]),    32'(m_q[i]));
                check($sformatf("tc%0d", i),   32'(tc_o[i]),
                      32'(up_dn ? (m_q[i] == MODS[i] - 1) : (m_q[i] == 0)));
                check($sformatf("wrap%0d", i), 32'(wrap_o[i]), 32'(m_wrap[i]));
                check($sformatf("sat%0d", i),  32'(sat_o[i]),  32'(m_sat[i]));
            end
        end
    end

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; load = 1'b0; en = 1'b1; up_dn = 1'b1; load_val = '0;

        // reset held with en high, then first tick after release
        repeat (3) edge1();
        check("rst_q",    32'(q_o[0]),    0);
        check("rst_wrap", 32'(wrap_o[0]), 0);
        check("rst_sat",  32'(sat_o[1]),  0);
        reset = 1'b0;
        edge1();
        check("first_tick_q", 32'(q_o[0]), 1);

        // mod-10 up sequence from 0
        clear = 1'b1; edge1(); clear = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            edge1();
            check($sformatf("m10_q_%0d", k),    32'(q_o[0]),    32'(k % 10));
            check($sformatf("m10_wrap_%0d", k), 32'(wrap_o[0]), 32'(k == 10));
            check($sformatf("m10_tc_%0d", k),   32'(tc_o[0]),   32'(k == 9));
        end

        // saturating down from 2
        load_val = 4'd2; load = 1'b1; up_dn = 1'b0; edge1(); load = 1'b0;
        check("sat_load_q", 32'(q_o[1]), 2);
        for (int k = 1; k <= 4; k++) begin
            edge1();
            check($sformatf("sat_q_%0d", k),   32'(q_o[1]),   32'((k == 1) ? 1 : 0));
            check($sformatf("sat_s_%0d", k),   32'(sat_o[1]), 32'(k >= 3));
            check($sformatf("sat_w_%0d", k),   32'(wrap_o[1]), 0);
        end
        clear = 1'b1; edge1(); clear = 1'b0;
        check("sat_clr_q", 32'(q_o[1]),   0);
        check("sat_clr_s", 32'(sat_o[1]), 0);

        // clear beats load, load clamp, down wrap from 0
        load_val = 4'd5; load = 1'b1; clear = 1'b1; edge1(); clear = 1'b0;
        check("clr_over_load", 32'(q_o[0]), 0);
        load_val = 4'd12; edge1(); load = 1'b0;
        check("clamp_a", 32'(q_o[0]), 9);
        check("clamp_b", 32'(q_o[1]), 9);
        clear = 1'b1; edge1(); clear = 1'b0;
        edge1();
        check("dnwrap_q", 32'(q_o[0]),    9);
        check("dnwrap_w", 32'(wrap_o[0]), 1);
        edge1();
        check("dnwrap_q2", 32'(q_o[0]),    8);
        check("dnwrap_w2", 32'(wrap_o[0]), 0);

        // prescale 3 with a 2-cycle enable gap
        up_dn = 1'b1; clear = 1'b1; edge1(); clear = 1'b0;
        edge1(); check("ps_e1", 32'(q_o[2]), 0);
        edge1(); check("ps_e2", 32'(q_o[2]), 0);
        edge1(); check("ps_e3", 32'(q_o[2]), 1);
        edge1(); check("ps_e4", 32'(q_o[2]), 1);
        en = 1'b0;
        edge1(); edge1(); check("ps_hold", 32'(q_o[2]), 1);
        en = 1'b1;
        edge1(); check("ps_e7", 32'(q_o[2]), 1);
        edge1(); check("ps_e8", 32'(q_o[2]), 2);

        // mid-count reset, prescaler restart, direction flip
        load_val = 4'd7; load = 1'b1; edge1(); load = 1'b0;
        edge1(); check("mid_q", 32'(q_o[0]), 8);
        reset = 1'b1; edge1(); reset = 1'b0;
        check("mid_rst_a", 32'(q_o[0]), 0);
        check("mid_rst_c", 32'(q_o[2]), 0);
        edge1(); check("rs_c1", 32'(q_o[2]), 0);
        edge1(); check("rs_c2", 32'(q_o[2]), 0);
        edge1(); check("rs_c3", 32'(q_o[2]), 1);
        check("rs_a3", 32'(q_o[0]), 3);
        up_dn = 1'b0;
        edge1(); check("flip_a", 32'(q_o[0]), 2);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            reset    = ($urandom_range(0, 199) == 0);
            clear    = ($urandom_range(0, 49) == 0);
            load     = ($urandom_range(0, 29) == 0);
            load_val = 4'($urandom_range(0, 15));
            en       = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) up_dn = ~up_dn;
            edge1();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
